// File: rtl/simon_pkg.sv
// simon_pkg: shared Simon32/64 key-schedule parameters, z0 sequence and types
package simon_pkg;
    localparam int N_WORD   = 16;
    localparam int M_WORDS  = 4;
    localparam int T_ROUNDS = 32;
    // Index 0 of the sequence is the MSB here, so z0[j] lives at bit 61-j
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    typedef enum logic [1:0] {IDLE, EXPAND, READY} ks_state_t;
    typedef logic [N_WORD-1:0] rk_word_t;
endpackage

// File: rtl/simon_key_expand_if.sv
// simon_key_expand_if: key load request and parallel round-key schedule bus
interface simon_key_expand_if;
    import simon_pkg::*;
    logic [N_WORD*M_WORDS-1:0]  key_in;
    logic                       key_load;
    logic                       busy;
    logic                       keys_valid;
    logic                       keys_done;
    logic [N_WORD*T_ROUNDS-1:0] rk_flat;
    modport master (output key_in, key_load, input busy, keys_valid, keys_done, rk_flat);
    modport slave  (input key_in, key_load, output busy, keys_valid, keys_done, rk_flat);
endinterface

// File: rtl/simon_key_round.sv
// simon_key_round: one Simon32/64 key-schedule step, rk[i] from rk[i-1], rk[i-3], rk[i-4] and z
module simon_key_round
    import simon_pkg::*;
(
    input  rk_word_t i_rk1,
    input  rk_word_t i_rk3,
    input  rk_word_t i_rk4,
    input  logic     i_z,
    output rk_word_t o_rk
);
    rk_word_t w_t0;
    rk_word_t w_t1;
    assign w_t0 = {i_rk1[2:0], i_rk1[N_WORD-1:3]} ^ i_rk3;
    assign w_t1 = w_t0 ^ {w_t0[0], w_t0[N_WORD-1:1]};
    assign o_rk = ~i_rk4 ^ w_t1 ^ {{(N_WORD-1){1'b0}}, i_z} ^ rk_word_t'(3);
endmodule

// File: rtl/simon_key_expand.sv
// simon_key_expand: iterative Simon32/64 key expansion, one round key per clock,
// full schedule held in registers and presented on a flat bus
module simon_key_expand
    import simon_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    simon_key_expand_if.slave bus
);
    ks_state_t  r_state;
    ks_state_t  w_next;
    logic [4:0] r_cnt;
    logic       r_done;
    rk_word_t   r_rk [T_ROUNDS];
    rk_word_t   w_rk_new;
    logic [5:0] w_zi;
    logic       w_last;

    assign w_last = (r_state == EXPAND) && (r_cnt == 5'(T_ROUNDS - 1));
    assign w_zi   = 6'(r_cnt) - 6'(M_WORDS);

    always_comb begin
        w_next = bus.key_load ? EXPAND : w_last ? READY : r_state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // A load always wins, so an in-flight expansion restarts from the new key
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
            for (int i = 0; i < T_ROUNDS; i++) r_rk[i] <= '0;
        end else begin
            r_done <= w_last && !bus.key_load;
            if (bus.key_load) begin
                for (int i = 0; i < M_WORDS; i++) r_rk[i] <= bus.key_in[N_WORD*i +: N_WORD];
                r_cnt <= 5'(M_WORDS);
            end else if (r_state == EXPAND) begin
                r_rk[r_cnt] <= w_rk_new;
                r_cnt       <= r_cnt + 5'd1;
            end
        end
    end

    simon_key_round u_round (
        .i_rk1 (r_rk[r_cnt - 5'd1]),
        .i_rk3 (r_rk[r_cnt - 5'd3]),
        .i_rk4 (r_rk[r_cnt - 5'd4]),
        .i_z   (Z0[6'd61 - w_zi]),
        .o_rk  (w_rk_new)
    );

    for (genvar g = 0; g < T_ROUNDS; g++) begin : g_flat
        assign bus.rk_flat[N_WORD*g +: N_WORD] = r_rk[g];
    end

    assign bus.busy       = (r_state == EXPAND);
    assign bus.keys_valid = (r_state == READY);
    assign bus.keys_done  = r_done;
endmodule

// File: tb/tb_simon_key_expand.sv
// tb_simon_key_expand: randomized key loads checked against a behavioural Simon32/64 schedule model
module tb_simon_key_expand;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    simon_key_expand_if bus();

    simon_key_expand dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rotr(input logic [15:0] x, input int r);
        return (x >> r) | (x << (16 - r));
    endfunction

    function automatic logic [15:0] rotl(input logic [15:0] x, input int r);
        return (x << r) | (x >> (16 - r));
    endfunction

    function automatic logic [511:0] model(input logic [63:0] k);
        string          z = "11111010001001010110000111001101111101000100101011000011100110";
        logic [15:0]    w [32];
        logic [15:0]    t;
        logic [511:0]   flat;
        for (int i = 0; i < 4; i++) w[i] = k[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            t = rotr(w[i-1], 3) ^ w[i-3];
            t = t ^ rotr(t, 1);
            w[i] = ~w[i-4] ^ t ^ 16'h0003 ^ ((z[i-4] == "1") ? 16'h0001 : 16'h0000);
        end
        for (int i = 0; i < 32; i++) flat[16*i +: 16] = w[i];
        return flat;
    endfunction

    function automatic logic [31:0] encrypt(input logic [511:0] rk, input logic [31:0] pt);
        logic [15:0] x, y, t;
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < 32; i++) begin
            t = y ^ ((rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2)) ^ rk[16*i +: 16];
            y = x;
            x = t;
        end
        return {x, y};
    endfunction

    task automatic load_key(input logic [63:0] k);
        @(negedge clk);
        bus.key_in   = k;
        bus.key_load = 1'b1;
        @(posedge clk);
        #1 bus.key_load = 1'b0;
        @(negedge clk);
    endtask

    // Counts edges after the load edge until keys_valid is seen, then one extra cycle for stray pulses
    task automatic run_to_valid(output int cycles, output int pulses, output int busy_cnt);
        cycles = 99; pulses = 0; busy_cnt = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            @(negedge clk);
            pulses += int'(bus.keys_done);
            busy_cnt += int'(bus.busy);
            if (bus.keys_valid) begin
                cycles = i;
                break;
            end
        end
        @(posedge clk);
        @(negedge clk);
        pulses += int'(bus.keys_done);
    endtask

    task automatic full_check(input string tag, input logic [63:0] k);
        int c, p, b;
        load_key(k);
        check({tag, "_busy_e0"}, 512'(bus.busy), 512'(1));
        check({tag, "_rk0_3"}, 512'(bus.rk_flat[63:0]), 512'(k));
        run_to_valid(c, p, b);
        check({tag, "_latency"}, 512'(c), 512'(28));
        check({tag, "_done_pulses"}, 512'(p), 512'(1));
        check({tag, "_busy_cycles"}, 512'(b), 512'(27));
        check({tag, "_valid_hold"}, 512'(bus.keys_valid), 512'(1));
        check({tag, "_sched"}, bus.rk_flat, model(k));
    endtask

    initial begin
        int c, p, b;
        logic [63:0] k;
        bus.key_in   = '0;
        bus.key_load = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 512'(bus.busy), 512'(0));
        check("rst_valid", 512'(bus.keys_valid), 512'(0));
        check("rst_done", 512'(bus.keys_done), 512'(0));
        check("rst_rk", bus.rk_flat, 512'(0));
        bus.key_in   = 64'h1918111009080100;
        bus.key_load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.key_load = 1'b0;
        check("load_in_rst_ignored", 512'({bus.busy, bus.rk_flat[63:0]}), 512'(0));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_busy", 512'(bus.busy), 512'(0));
        check("post_rst_valid", 512'(bus.keys_valid), 512'(0));
        check("post_rst_rk", bus.rk_flat, 512'(0));

        load_key(64'h1918111009080100);
        check("std_rk0_3", 512'(bus.rk_flat[63:0]), 512'(64'h1918111009080100));
        @(posedge clk);
        @(negedge clk);
        check("std_rk4", 512'(bus.rk_flat[79:64]), 512'(16'h71C3));
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("std_sched", bus.rk_flat, model(64'h1918111009080100));
        check("std_cipher", 512'(encrypt(bus.rk_flat, 32'h65656877)), 512'(32'hC69BE9BB));

        full_check("std_full", 64'h1918111009080100);
        for (int n = 0; n < 4; n++) begin
            k = {$urandom, $urandom};
            full_check($sformatf("rand%0d", n), k);
        end

        k = {$urandom, $urandom};
        load_key(k);
        p = 0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            @(negedge clk);
            p += int'(bus.keys_done) + int'(bus.keys_valid);
        end
        check("mid_no_valid", 512'(p), 512'(0));
        load_key(64'h0);
        check("mid_reload_busy", 512'(bus.busy), 512'(1));
        run_to_valid(c, p, b);
        check("mid_latency", 512'(c), 512'(28));
        check("mid_done_pulses", 512'(p), 512'(1));
        check("mid_sched", bus.rk_flat, model(64'h0));

        k = {$urandom, $urandom};
        load_key(k);
        check("ready_reload_valid", 512'(bus.keys_valid), 512'(0));
        check("ready_reload_busy", 512'(bus.busy), 512'(1));
        run_to_valid(c, p, b);
        check("ready_latency", 512'(c), 512'(28));
        check("ready_sched", bus.rk_flat, model(k));

        load_key({$urandom, $urandom});
        repeat (14) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_busy", 512'(bus.busy), 512'(0));
        check("async_rk", bus.rk_flat, 512'(0));
        @(negedge clk);
        rst = 1'b1;
        p = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            p += int'(bus.keys_valid) + int'(bus.keys_done) + int'(bus.busy);
        end
        check("async_no_resume", 512'(p), 512'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
